axil_mem_slave: RTL and testbench
=================================

Name: axil_mem_slave

Overview:
- Parametrised AXI4-Lite slave memory responder for the mriscvcore master port.
- Replaces free-running random slave inputs in core-level benches and formal harnesses with a real, ordered responder:
  - word-addressed storage with byte strobes
  - programmable read and write latency
  - out-of-range error responses
  - an external stall input that injects back-pressure.

Parameters:
- DATA_W, 32, data bus width in bits; multiple of 8.
- ADDR_W, 32, address bus width.
- DEPTH_LOG2, 10, log2 of memory depth in DATA_W words.
- BASE_ADDR, 0, byte address of word 0; aligned to DATA_W/8 × 2^DEPTH_LOG2.
- RD_LAT, 0, extra wait cycles between AR handshake and Rvalid (0..15).
- WR_LAT, 0, extra wait cycles between write commit and Bvalid (0..15).
- INIT_FILE, "", optional $readmemh image; empty means no preload.

Ports:
- clk  in  1  clock; all activity on rising edge.
- rstn  in  1  asynchronous, active-low reset.
- stall  in  1  when high, forces ARready, AWready and Wready low; does not affect Rvalid/Bvalid.
- AWdata  in  ADDR_W  write address.
- AWvalid  in  1  write address valid.
- AWprot  in  3  ignored.
- AWready  out  1  write address ready.
- Wdata  in  DATA_W  write data.
- Wstrb  in  DATA_W/8  byte enables.
- Wvalid  in  1  write data valid.
- Wready  out  1  write data ready.
- Bvalid  out  1  write response valid.
- Bresp  out  2  00 OKAY, 10 SLVERR.
- Bready  in  1  write response ready.
- ARdata  in  ADDR_W  read address.
- ARvalid  in  1  read address valid.
- ARprot  in  3  ignored.
- ARready  out  1  read address ready.
- Rdata  out  DATA_W  read data.
- Rresp  out  2  00 OKAY, 10 SLVERR.
- Rvalid  out  1  read data valid.
- Rready  in  1  read data ready.

Behaviour:
- Reset (rstn low, asynchronous): all ready/valid outputs low; Bresp=Rresp=00; Rdata=0; both FSMs idle; latency counters 0. Memory contents are not reset.
- Address decode:
  - word index = (addr − BASE_ADDR) >> log2(DATA_W/8), low DEPTH_LOG2 bits.
  - In range iff BASE_ADDR ≤ addr < BASE_ADDR + (DATA_W/8 × 2^DEPTH_LOG2).
  - Low address bits below word alignment are ignored.
- Write FSM:
  - W_COLLECT: AWready = !aw_held && !stall; Wready = !w_held && !stall.
    - AW and W handshakes are independent, in either order or the same cycle; each is captured into a holding register.
    - The edge at which both are held (or both handshake together) is the commit edge. At that edge, an in-range address writes the bytes with Wstrb=1; other bytes are unchanged.
    - An out-of-range address writes nothing and records SLVERR.
    - Next state is W_WAIT if WR_LAT>0, else W_RESP.
  - W_WAIT: count WR_LAT cycles, then W_RESP.
  - W_RESP: Bvalid=1, Bresp stable; on Bvalid&&Bready, clear holds and return to W_COLLECT with Bvalid low next cycle.
  - Latency: Bvalid is first high WR_LAT+1 cycles after the commit edge.
  - Only one outstanding write. The second channel's ready stays low once its holding register is full.
- Read FSM:
  - R_IDLE: ARready = !stall. At the AR handshake edge, the memory word is sampled into Rdata, or Rdata=0 with SLVERR if out of range. Next state is R_WAIT if RD_LAT>0, else R_RESP.
  - R_WAIT: count RD_LAT cycles, then R_RESP.
  - R_RESP: Rvalid=1; Rdata/Rresp stable while Rvalid && !Rready. On handshake, return to R_IDLE; ARready may be high in the very next cycle.
  - Latency: Rvalid is first high RD_LAT+1 cycles after the AR handshake edge.
  - Only one outstanding read.
- Simultaneous events:
  - Read and write channels are fully independent.
  - A write commit and an AR handshake on the same edge to the same word: the read returns the pre-write data.
- stall:
  - Asserting stall mid-transaction freezes acceptance only; pending responses complete normally.
  - stall has no effect on held data.
- Reset mid-operation: all transactions are aborted; writes already committed remain in memory.
- Valid outputs never drop without a handshake.

Test Plan:
- Reset, then AW=BASE+0x10 and W=0xDEADBEEF with Wstrb=1111 in the same cycle, WR_LAT=0 → Bvalid high the next cycle with Bresp=00. AR=BASE+0x10, RD_LAT=0 → Rvalid next cycle, Rdata=0xDEADBEEF.
- W (0x000000AA, Wstrb=0001) presented 3 cycles before AW to the same address as above → AWready low is never asserted spuriously; commit occurs on the AW edge; a subsequent read returns 0xDEADBEAA.
- RD_LAT=3, WR_LAT=2, Rready held low for 4 cycles after Rvalid → Rvalid rises exactly 4 cycles after the AR edge and Rdata stays stable until Rready; Bvalid rises 3 cycles after commit.
- AR=BASE+4×2^DEPTH_LOG2 (first out-of-range address) and a write to the same address → Rresp=10 with Rdata=0, Bresp=10, and memory is unchanged.
- stall=1 for 5 cycles with AWvalid, Wvalid and ARvalid held high → all readies stay low; the handshakes complete on the first cycle after stall falls.
- Same-edge write commit of 0x11111111 and AR to the same word holding 0x22222222 → read returns 0x22222222; a following read returns 0x11111111. Separately, rstn pulsed low mid-R_WAIT → Rvalid and ARready low immediately, FSM in R_IDLE.

Source files
------------

// File: rtl/axil_mem_slave.sv
// AXI4-Lite slave memory responder with byte strobes, programmable
// read/write latency, out-of-range SLVERR and an acceptance stall input.
module axil_mem_slave #(
    parameter int                DATA_W     = 32,
    parameter int                ADDR_W     = 32,
    parameter int                DEPTH_LOG2 = 10,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
    parameter int                RD_LAT     = 0,
    parameter int                WR_LAT     = 0,
    parameter string             INIT_FILE  = ""
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                stall,
    input  logic [ADDR_W-1:0]   AWdata,
    input  logic                AWvalid,
    input  logic [2:0]          AWprot,
    output logic                AWready,
    input  logic [DATA_W-1:0]   Wdata,
    input  logic [DATA_W/8-1:0] Wstrb,
    input  logic                Wvalid,
    output logic                Wready,
    output logic                Bvalid,
    output logic [1:0]          Bresp,
    input  logic                Bready,
    input  logic [ADDR_W-1:0]   ARdata,
    input  logic                ARvalid,
    input  logic [2:0]          ARprot,
    output logic                ARready,
    output logic [DATA_W-1:0]   Rdata,
    output logic [1:0]          Rresp,
    output logic                Rvalid,
    input  logic                Rready
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFFB  = $clog2(BYTES);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    localparam logic [ADDR_W:0] ONE_X  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] SPAN   = ONE_X << (OFFB + DEPTH_LOG2);
    localparam logic [ADDR_W:0] BASE_X = {1'b0, BASE_ADDR};

    localparam logic [3:0] WL_LAST = 4'((WR_LAT > 0) ? WR_LAT - 1 : 0);
    localparam logic [3:0] RL_LAST = 4'((RD_LAT > 0) ? RD_LAT - 1 : 0);

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [1:0] {W_COLLECT, W_WAIT, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rstate_t;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        logic [ADDR_W:0] ax;
        ax = {1'b0, a};
        return (ax >= BASE_X) && ((ax - BASE_X) < SPAN);
    endfunction

    function automatic logic [DEPTH_LOG2-1:0] word_idx(input logic [ADDR_W-1:0] a);
        return DEPTH_LOG2'((a - BASE_ADDR) >> OFFB);
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];

    wstate_t           w_state, w_next;
    logic              aw_held, w_held;
    logic [ADDR_W-1:0] aw_addr;
    logic [DATA_W-1:0] w_data;
    logic [BYTES-1:0]  w_strb;
    logic [3:0]        w_cnt;
    logic [1:0]        b_resp;

    logic              aw_hs, w_hs, commit;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_data;
    logic [BYTES-1:0]  c_strb;

    rstate_t           r_state, r_next;
    logic [3:0]        r_cnt;
    logic [DATA_W-1:0] r_data;
    logic [1:0]        r_resp;
    logic              ar_hs;

    logic              unused_prot;

    assign unused_prot = ^{AWprot, ARprot};

    assign aw_hs  = AWvalid && AWready;
    assign w_hs   = Wvalid && Wready;
    assign commit = (w_state == W_COLLECT) &&
                    (aw_held || aw_hs) && (w_held || w_hs);
    assign c_addr = aw_held ? aw_addr : AWdata;
    assign c_data = w_held ? w_data : Wdata;
    assign c_strb = w_held ? w_strb : Wstrb;
    assign Bresp  = b_resp;

    // Write FSM state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) w_state <= W_COLLECT;
        else       w_state <= w_next;
    end

    // Write FSM next state: collect both channels, wait, respond
    always_comb begin
        w_next = w_state;
        unique case (w_state)
            W_COLLECT: if (commit) w_next = (WR_LAT > 0) ? W_WAIT : W_RESP;
            W_WAIT:    if (w_cnt == WL_LAST) w_next = W_RESP;
            W_RESP:    if (Bready) w_next = W_COLLECT;
            default:   w_next = W_COLLECT;
        endcase
    end

    // Write FSM outputs; a full holding register closes its channel
    always_comb begin
        AWready = 1'b0;
        Wready  = 1'b0;
        Bvalid  = 1'b0;
        unique case (w_state)
            W_COLLECT: begin
                AWready = rstn && !aw_held && !stall;
                Wready  = rstn && !w_held && !stall;
            end
            W_RESP:  Bvalid = 1'b1;
            default: ;
        endcase
    end

    // Write holding registers, latency counter and response code
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            aw_addr <= '0;
            w_data  <= '0;
            w_strb  <= '0;
            w_cnt   <= '0;
            b_resp  <= OKAY;
        end else begin
            if (aw_hs) begin
                aw_held <= 1'b1;
                aw_addr <= AWdata;
            end
            if (w_hs) begin
                w_held <= 1'b1;
                w_data <= Wdata;
                w_strb <= Wstrb;
            end
            if (commit) begin
                b_resp <= in_range(c_addr) ? OKAY : SLVERR;
                w_cnt  <= '0;
            end else if (w_state == W_WAIT) begin
                w_cnt <= w_cnt + 4'd1;
            end
            if (Bvalid && Bready) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end
        end
    end

    // Storage: byte-strobed write on the commit edge, never reset
    always_ff @(posedge clk) begin
        if (commit && in_range(c_addr)) begin
            for (int i = 0; i < BYTES; i++) begin
                if (c_strb[i])
                    mem[word_idx(c_addr)][8*i +: 8] <= c_data[8*i +: 8];
            end
        end
    end

    assign ar_hs = ARvalid && ARready;
    assign Rdata = r_data;
    assign Rresp = r_resp;

    // Read FSM state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= R_IDLE;
        else       r_state <= r_next;
    end

    // Read FSM next state: accept, wait, respond
    always_comb begin
        r_next = r_state;
        unique case (r_state)
            R_IDLE:  if (ar_hs) r_next = (RD_LAT > 0) ? R_WAIT : R_RESP;
            R_WAIT:  if (r_cnt == RL_LAST) r_next = R_RESP;
            R_RESP:  if (Rready) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    // Read FSM outputs
    always_comb begin
        ARready = 1'b0;
        Rvalid  = 1'b0;
        unique case (r_state)
            R_IDLE:  ARready = rstn && !stall;
            R_RESP:  Rvalid = 1'b1;
            default: ;
        endcase
    end

    // Read sample at the AR edge; sees pre-write data on a same-edge commit
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_data <= '0;
            r_resp <= OKAY;
            r_cnt  <= '0;
        end else if (ar_hs) begin
            r_cnt <= '0;
            if (in_range(ARdata)) begin
                r_data <= mem[word_idx(ARdata)];
                r_resp <= OKAY;
            end else begin
                r_data <= '0;
                r_resp <= SLVERR;
            end
        end else if (r_state == R_WAIT) begin
            r_cnt <= r_cnt + 4'd1;
        end
    end

endmodule

// File: tb/tb_axil_mem_slave.sv
// Directed bench for axil_mem_slave: one zero-latency instance and one
// with RD_LAT=3 / WR_LAT=2, both on a 16-word window at 0x1000.
module tb_axil_mem_slave;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn     [2];
    logic        stall    [2];
    logic [31:0] aw_addr  [2];
    logic        aw_valid [2];
    logic        aw_ready [2];
    logic [31:0] w_data   [2];
    logic [3:0]  w_strb   [2];
    logic        w_valid  [2];
    logic        w_ready  [2];
    logic        b_valid  [2];
    logic [1:0]  b_resp   [2];
    logic        b_ready  [2];
    logic [31:0] ar_addr  [2];
    logic        ar_valid [2];
    logic        ar_ready [2];
    logic [31:0] r_data   [2];
    logic [1:0]  r_resp   [2];
    logic        r_valid  [2];
    logic        r_ready  [2];

    int n_tests = 0;
    int n_fail  = 0;

    axil_mem_slave #(
        .DATA_W(32), .ADDR_W(32), .DEPTH_LOG2(4),
        .BASE_ADDR(32'h1000), .RD_LAT(0), .WR_LAT(0), .INIT_FILE("")
    ) dut0 (
        .clk(clk), .rstn(rstn[0]), .stall(stall[0]),
        .AWdata(aw_addr[0]), .AWvalid(aw_valid[0]), .AWprot(3'b000),
        .AWready(aw_ready[0]),
        .Wdata(w_data[0]), .Wstrb(w_strb[0]), .Wvalid(w_valid[0]),
        .Wready(w_ready[0]),
        .Bvalid(b_valid[0]), .Bresp(b_resp[0]), .Bready(b_ready[0]),
        .ARdata(ar_addr[0]), .ARvalid(ar_valid[0]), .ARprot(3'b000),
        .ARready(ar_ready[0]),
        .Rdata(r_data[0]), .Rresp(r_resp[0]), .Rvalid(r_valid[0]),
        .Rready(r_ready[0])
    );

    axil_mem_slave #(
        .DATA_W(32), .ADDR_W(32), .DEPTH_LOG2(4),
        .BASE_ADDR(32'h1000), .RD_LAT(3), .WR_LAT(2), .INIT_FILE("")
    ) dut1 (
        .clk(clk), .rstn(rstn[1]), .stall(stall[1]),
        .AWdata(aw_addr[1]), .AWvalid(aw_valid[1]), .AWprot(3'b000),
        .AWready(aw_ready[1]),
        .Wdata(w_data[1]), .Wstrb(w_strb[1]), .Wvalid(w_valid[1]),
        .Wready(w_ready[1]),
        .Bvalid(b_valid[1]), .Bresp(b_resp[1]), .Bready(b_ready[1]),
        .ARdata(ar_addr[1]), .ARvalid(ar_valid[1]), .ARprot(3'b000),
        .ARready(ar_ready[1]),
        .Rdata(r_data[1]), .Rresp(r_resp[1]), .Rvalid(r_valid[1]),
        .Rready(r_ready[1])
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Both channels in the same cycle; lat is the expected Bvalid delay
    task automatic wr(input int d, input logic [31:0] a, input logic [31:0] v,
                      input logic [3:0] s, input logic [1:0] er,
                      input int lat, input string tag);
        int n;
        aw_addr[d]  = a;
        w_data[d]   = v;
        w_strb[d]   = s;
        aw_valid[d] = 1'b1;
        w_valid[d]  = 1'b1;
        #1;
        n = 0;
        while (!(aw_ready[d] && w_ready[d]) && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk({tag, "_accept"}, 32'(n < 20), 32'd1);
        @(negedge clk);
        aw_valid[d] = 1'b0;
        w_valid[d]  = 1'b0;
        n = 1;
        while (!b_valid[d] && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_blat"}, 32'(n), 32'(lat + 1));
        chk({tag, "_bresp"}, 32'(b_resp[d]), 32'(er));
        @(negedge clk);
        chk({tag, "_bdrop"}, 32'(b_valid[d]), 32'd0);
    endtask

    // Read with expected data/resp/latency; Rready held low for hold cycles
    task automatic rd(input int d, input logic [31:0] a, input logic [31:0] ev,
                      input logic [1:0] er, input int lat, input int hold,
                      input string tag);
        int n;
        ar_addr[d]  = a;
        ar_valid[d] = 1'b1;
        r_ready[d]  = (hold == 0);
        #1;
        n = 0;
        while (!ar_ready[d] && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk({tag, "_accept"}, 32'(n < 20), 32'd1);
        @(negedge clk);
        ar_valid[d] = 1'b0;
        n = 1;
        while (!r_valid[d] && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_rlat"}, 32'(n), 32'(lat + 1));
        chk({tag, "_rdata"}, r_data[d], ev);
        chk({tag, "_rresp"}, 32'(r_resp[d]), 32'(er));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "_hold_valid"}, 32'(r_valid[d]), 32'd1);
            chk({tag, "_hold_data"}, r_data[d], ev);
        end
        r_ready[d] = 1'b1;
        @(negedge clk);
        chk({tag, "_rdrop"}, 32'(r_valid[d]), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            rstn[d]     = 1'b0;
            stall[d]    = 1'b0;
            aw_addr[d]  = '0;
            aw_valid[d] = 1'b0;
            w_data[d]   = '0;
            w_strb[d]   = '0;
            w_valid[d]  = 1'b0;
            b_ready[d]  = 1'b1;
            ar_addr[d]  = '0;
            ar_valid[d] = 1'b0;
            r_ready[d]  = 1'b1;
        end

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_awready", 32'(aw_ready[0]), 32'd0);
        chk("rst_wready", 32'(w_ready[0]), 32'd0);
        chk("rst_arready", 32'(ar_ready[0]), 32'd0);
        chk("rst_bvalid", 32'(b_valid[0]), 32'd0);
        chk("rst_rvalid", 32'(r_valid[0]), 32'd0);
        chk("rst_resp", 32'({b_resp[0], r_resp[0]}), 32'd0);
        chk("rst_rdata", r_data[0], 32'd0);
        chk("rst_arready1", 32'(ar_ready[1]), 32'd0);
        rstn[0] = 1'b1;
        rstn[1] = 1'b1;
        @(negedge clk);
        chk("post_rst_arready", 32'(ar_ready[0]), 32'd1);

        // Basic same-cycle write then read
        wr(0, 32'h1010, 32'hDEADBEEF, 4'hF, 2'b00, 0, "w_basic");
        rd(0, 32'h1010, 32'hDEADBEEF, 2'b00, 0, 0, "r_basic");

        // W leads AW by three edges
        w_data[0]  = 32'h000000AA;
        w_strb[0]  = 4'b0001;
        w_valid[0] = 1'b1;
        #1;
        chk("wlead_wready", 32'(w_ready[0]), 32'd1);
        @(negedge clk);
        w_valid[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("wlead_wready_held", 32'(w_ready[0]), 32'd0);
            chk("wlead_awready", 32'(aw_ready[0]), 32'd1);
            chk("wlead_no_commit", 32'(b_valid[0]), 32'd0);
            if (i < 2) @(negedge clk);
        end
        aw_addr[0]  = 32'h1010;
        aw_valid[0] = 1'b1;
        @(negedge clk);
        aw_valid[0] = 1'b0;
        chk("wlead_bvalid", 32'(b_valid[0]), 32'd1);
        chk("wlead_bresp", 32'(b_resp[0]), 32'd0);
        @(negedge clk);
        chk("wlead_bdrop", 32'(b_valid[0]), 32'd0);
        rd(0, 32'h1010, 32'hDEADBEAA, 2'b00, 0, 0, "r_wlead");

        // Top word, partial strobes
        wr(0, 32'h103C, 32'hA1B2C3D4, 4'hF, 2'b00, 0, "w_top");
        wr(0, 32'h103E, 32'hFFFFFFFF, 4'b0110, 2'b00, 0, "w_top_strb");
        rd(0, 32'h103C, 32'hA1FFFFD4, 2'b00, 0, 0, "r_top");

        // Out of range: first address past the window and just below base
        wr(0, 32'h1000, 32'h0BADF00D, 4'hF, 2'b00, 0, "w_base");
        wr(0, 32'h1040, 32'h55555555, 4'hF, 2'b10, 0, "w_oor");
        rd(0, 32'h1040, 32'h00000000, 2'b10, 0, 0, "r_oor");
        rd(0, 32'h1000, 32'h0BADF00D, 2'b00, 0, 0, "r_noalias");
        wr(0, 32'h0FFC, 32'h66666666, 4'hF, 2'b10, 0, "w_below");
        rd(0, 32'h0FFC, 32'h00000000, 2'b10, 0, 0, "r_below");
        rd(0, 32'h103C, 32'hA1FFFFD4, 2'b00, 0, 0, "r_top_kept");

        // Stall holds off all three address/data channels
        stall[0]    = 1'b1;
        aw_addr[0]  = 32'h1020;
        w_data[0]   = 32'h11223344;
        w_strb[0]   = 4'hF;
        ar_addr[0]  = 32'h1010;
        aw_valid[0] = 1'b1;
        w_valid[0]  = 1'b1;
        ar_valid[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_awready", 32'(aw_ready[0]), 32'd0);
            chk("stall_wready", 32'(w_ready[0]), 32'd0);
            chk("stall_arready", 32'(ar_ready[0]), 32'd0);
            @(negedge clk);
        end
        chk("stall_no_resp", 32'({b_valid[0], r_valid[0]}), 32'd0);
        stall[0] = 1'b0;
        #1;
        chk("unstall_ready", 32'({aw_ready[0], w_ready[0], ar_ready[0]}), 32'd7);
        @(negedge clk);
        aw_valid[0] = 1'b0;
        w_valid[0]  = 1'b0;
        ar_valid[0] = 1'b0;
        chk("unstall_bvalid", 32'(b_valid[0]), 32'd1);
        chk("unstall_rvalid", 32'(r_valid[0]), 32'd1);
        chk("unstall_rdata", r_data[0], 32'hDEADBEAA);
        @(negedge clk);
        chk("unstall_drop", 32'({b_valid[0], r_valid[0]}), 32'd0);
        rd(0, 32'h1020, 32'h11223344, 2'b00, 0, 0, "r_unstall");

        // Same-edge commit and read of one word
        wr(0, 32'h1018, 32'h22222222, 4'hF, 2'b00, 0, "w_pre");
        aw_addr[0]  = 32'h1018;
        w_data[0]   = 32'h11111111;
        w_strb[0]   = 4'hF;
        ar_addr[0]  = 32'h1018;
        aw_valid[0] = 1'b1;
        w_valid[0]  = 1'b1;
        ar_valid[0] = 1'b1;
        #1;
        chk("same_ready", 32'({aw_ready[0], w_ready[0], ar_ready[0]}), 32'd7);
        @(negedge clk);
        aw_valid[0] = 1'b0;
        w_valid[0]  = 1'b0;
        ar_valid[0] = 1'b0;
        chk("same_rdata", r_data[0], 32'h22222222);
        chk("same_bvalid", 32'(b_valid[0]), 32'd1);
        @(negedge clk);
        rd(0, 32'h1018, 32'h11111111, 2'b00, 0, 0, "r_after_same");

        // Latency instance with Rready back-pressure
        wr(1, 32'h1008, 32'h12345678, 4'hF, 2'b00, 2, "w_lat");
        rd(1, 32'h1008, 32'h12345678, 2'b00, 3, 4, "r_lat");

        // Reset pulse while the read is waiting
        ar_addr[1]  = 32'h1008;
        ar_valid[1] = 1'b1;
        #1;
        chk("rwait_accept", 32'(ar_ready[1]), 32'd1);
        @(negedge clk);
        ar_valid[1] = 1'b0;
        chk("rwait_rvalid", 32'(r_valid[1]), 32'd0);
        #2;
        rstn[1] = 1'b0;
        #1;
        chk("rst_mid_rvalid", 32'(r_valid[1]), 32'd0);
        chk("rst_mid_arready", 32'(ar_ready[1]), 32'd0);
        @(negedge clk);
        rstn[1] = 1'b1;
        #1;
        chk("rst_mid_idle", 32'(ar_ready[1]), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rst_mid_no_resp", 32'(r_valid[1]), 32'd0);
        end
        rd(1, 32'h1008, 32'h12345678, 2'b00, 3, 0, "r_after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
